// File: rtl/pwm_ramp_sched.sv
// Duty-ramp scheduler: walks each PWM channel's live duty toward min(target, period)
// in bounded steps, using one shared add/compare datapath scanned round-robin.
module pwm_ramp_sched #(
    parameter int NCH = 4,
    parameter int DW  = 28,
    parameter int SW  = 16,
    parameter int TW  = 24
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [TW-1:0]     TICK_DIV,
    input  logic [SW-1:0]     STEP,
    input  logic [NCH*DW-1:0] TGT_DUTY,
    input  logic [NCH*DW-1:0] PERIOD,
    output logic [NCH*DW-1:0] DECODE,
    output logic [NCH-1:0]    BUSY,
    output logic              SETTLED
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [NCH*DW-1:0]   decode_q, decode_d;
    logic                any_busy_q, settled_q, settled_d;

    logic                tick_s, wr_en_s;
    logic [DW-1:0]       eff_tgt_s [NCH];
    logic [NCH-1:0]      busy_s;
    logic [DW-1:0]       cur_s, tgt_s, new_s;
    logic [DW:0]         up_diff_s, dn_diff_s, step_ext_s;

    // Effective target is the duty clamped to the period; busy while not there yet.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (TGT_DUTY[i*DW +: DW] < PERIOD[i*DW +: DW]) begin
                eff_tgt_s[i] = TGT_DUTY[i*DW +: DW];
            end else begin
                eff_tgt_s[i] = PERIOD[i*DW +: DW];
            end
            busy_s[i] = (decode_q[i*DW +: DW] != eff_tgt_s[i]);
        end
    end

    assign tick_s = EN && (cnt_q == TICK_DIV);

    // Prescaler next state: free-runs while enabled, parked at zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!EN) begin
            cnt_d = {TW{1'b0}};
        end else if (tick_s) begin
            cnt_d = {TW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Shared step datapath for the channel currently under scan.
    always_comb begin
        cur_s      = decode_q[idx_q*DW +: DW];
        tgt_s      = eff_tgt_s[idx_q];
        step_ext_s = {{(DW+1-SW){1'b0}}, STEP};
        up_diff_s  = {1'b0, tgt_s} - {1'b0, cur_s};
        dn_diff_s  = {1'b0, cur_s} - {1'b0, tgt_s};
        new_s      = cur_s;
        if (cur_s == tgt_s) begin
            new_s = cur_s;
        end else if (STEP == {SW{1'b0}}) begin
            new_s = tgt_s;
        end else if (cur_s < tgt_s) begin
            new_s = (up_diff_s <= step_ext_s) ? tgt_s : cur_s + step_ext_s[DW-1:0];
        end else begin
            new_s = (dn_diff_s <= step_ext_s) ? tgt_s : cur_s - step_ext_s[DW-1:0];
        end
    end

    // Scan FSM: a tick during a scan is remembered once and restarts the scan without a gap.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        wr_en_s   = 1'b0;
        if (!EN) begin
            state_d   = IDLE;
            idx_d     = {IW{1'b0}};
            pending_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_s) begin
                        state_d = SCAN;
                        idx_d   = {IW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    wr_en_s = 1'b1;
                    if (idx_q == IW'(NCH-1)) begin
                        idx_d     = {IW{1'b0}};
                        pending_d = 1'b0;
                        if (pending_q || tick_s) begin
                            state_d = SCAN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + {{(IW-1){1'b0}}, 1'b1};
                        pending_d = pending_q | tick_s;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    idx_d     = {IW{1'b0}};
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    // Duty write-back and settle-edge detection.
    always_comb begin
        decode_d = decode_q;
        if (wr_en_s) begin
            decode_d[idx_q*DW +: DW] = new_s;
        end else begin
            decode_d = decode_q;
        end
        settled_d = any_busy_q & ~(|busy_s);
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            idx_q      <= {IW{1'b0}};
            pending_q  <= 1'b0;
            cnt_q      <= {TW{1'b0}};
            decode_q   <= {(NCH*DW){1'b0}};
            any_busy_q <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            decode_q   <= decode_d;
            any_busy_q <= |busy_s;
            settled_q  <= settled_d;
        end
    end

    assign DECODE  = decode_q;
    assign BUSY    = busy_s;
    assign SETTLED = settled_q;

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Directed bench for pwm_ramp_sched: ramp up/down, clamping, round-robin timing,
// tick dropping, freeze, async reset and full-range boundary.
module tb_pwm_ramp_sched;

    localparam int NCH = 4;
    localparam int DW  = 28;
    localparam int SW  = 16;
    localparam int TW  = 24;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              EN;
    logic [TW-1:0]     TICK_DIV;
    logic [SW-1:0]     STEP;
    logic [NCH*DW-1:0] TGT_DUTY;
    logic [NCH*DW-1:0] PERIOD;
    logic [NCH*DW-1:0] DECODE;
    logic [NCH-1:0]    BUSY;
    logic              SETTLED;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_ramp_sched #(.NCH(NCH), .DW(DW), .SW(SW), .TW(TW)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP),
        .TGT_DUTY (TGT_DUTY),
        .PERIOD   (PERIOD),
        .DECODE   (DECODE),
        .BUSY     (BUSY),
        .SETTLED  (SETTLED)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] dec(input int i);
        return {4'h0, DECODE[i*DW +: DW]};
    endfunction

    task automatic set_ch(input int i, input logic [DW-1:0] t, input logic [DW-1:0] p);
        TGT_DUTY[i*DW +: DW] = t;
        PERIOD[i*DW +: DW]   = p;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_v;

    initial begin
        RST_N    = 1'b0;
        EN       = 1'b0;
        TICK_DIV = 24'd0;
        STEP     = 16'd0;
        TGT_DUTY = '0;
        PERIOD   = '0;
        cyc(2);
        chk("rst_decode_lo", DECODE[31:0], 32'd0);
        chk("rst_decode_hi", {20'd0, DECODE[NCH*DW-1:100]}, 32'd0);
        chk("rst_settled", {31'd0, SETTLED}, 32'd0);
        chk("rst_busy", {28'd0, BUSY}, 32'd0);

        // Ramp-up on channel 0
        STEP = 16'd30;
        set_ch(0, 28'd100, 28'd1000);
        #1;
        chk("busy_after_tgt", {28'd0, BUSY}, 32'd1);
        RST_N = 1'b1;
        EN    = 1'b1;
        cyc(2);  chk("up_30", dec(0), 32'd30);
        cyc(4);  chk("up_60", dec(0), 32'd60);
        cyc(4);  chk("up_90", dec(0), 32'd90);
        cyc(3);  chk("up_busy_before", {28'd0, BUSY}, 32'd1);
        cyc(1);  chk("up_100", dec(0), 32'd100);
                 chk("up_busy_drop", {28'd0, BUSY}, 32'd0);
                 chk("up_settled_not_yet", {31'd0, SETTLED}, 32'd0);
        cyc(1);  chk("up_settled_pulse", {31'd0, SETTLED}, 32'd1);
        cyc(1);  chk("up_settled_end", {31'd0, SETTLED}, 32'd0);

        // Ramp-down with clamp at the target, then period clamp with STEP=0
        TGT_DUTY[0*DW +: DW] = 28'd10;
        STEP = 16'd40;
        cyc(2);  chk("dn_60", dec(0), 32'd60);
        cyc(4);  chk("dn_20", dec(0), 32'd20);
        cyc(4);  chk("dn_10", dec(0), 32'd10);
        cyc(4);  chk("dn_hold_10", dec(0), 32'd10);
        set_ch(1, 28'd5000, 28'd2000);
        STEP = 16'd0;
        #1;
        chk("clamp_busy", {28'd0, BUSY}, 32'd2);
        cyc(1);  chk("clamp_jump", dec(1), 32'd2000);
                 chk("clamp_busy_clear", {28'd0, BUSY}, 32'd0);

        // Round-robin timing with TICK_DIV=9
        EN = 1'b0;
        TICK_DIV = 24'd9;
        STEP = 16'd50;
        for (int i = 0; i < NCH; i++) set_ch(i, 28'd50, 28'd1000);
        cyc(2);
        EN = 1'b1;
        cyc(10); chk("rr_ch0_wait", dec(0), 32'd10);
        cyc(1);  chk("rr_ch0", dec(0), 32'd50);
                 chk("rr_ch1_wait", dec(1), 32'd2000);
        cyc(1);  chk("rr_ch1", dec(1), 32'd1950);
                 chk("rr_ch2_wait", dec(2), 32'd0);
        cyc(1);  chk("rr_ch2", dec(2), 32'd50);
                 chk("rr_ch3_wait", dec(3), 32'd0);
        cyc(1);  chk("rr_ch3", dec(3), 32'd50);
        cyc(6);  chk("rr_tick2_wait", dec(1), 32'd1950);
        cyc(2);  chk("rr_tick2", dec(1), 32'd1900);

        // TICK_DIV=1: back-to-back scans, surplus ticks dropped
        EN = 1'b0;
        TICK_DIV = 24'd1;
        cyc(2);
        EN = 1'b1;
        cyc(3);  chk("b2b_before", dec(1), 32'd1900);
        cyc(1);  chk("b2b_scan1", dec(1), 32'd1850);
        cyc(3);  chk("b2b_nogap_wait", dec(1), 32'd1850);
        cyc(1);  chk("b2b_scan2", dec(1), 32'd1800);
        TICK_DIV = 24'd1000;
        cyc(4);  chk("b2b_scan3", dec(1), 32'd1750);
        cyc(8);  chk("b2b_dropped", dec(1), 32'd1750);

        // Freeze mid-ramp
        EN = 1'b0;
        TICK_DIV = 24'd3;
        TGT_DUTY[0*DW +: DW] = 28'd100;
        STEP = 16'd10;
        cyc(2);
        EN = 1'b1;
        cyc(4);  chk("frz_pre", dec(0), 32'd50);
        cyc(1);  chk("frz_60", dec(0), 32'd60);
        EN = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("frz_hold", dec(0), 32'd60);
            chk("frz_no_settled", {31'd0, SETTLED}, 32'd0);
        end
        chk("frz_ch1_hold", dec(1), 32'd1750);
        EN = 1'b1;
        cyc(4);  chk("frz_reen_wait", dec(0), 32'd60);
        cyc(1);  chk("frz_reen_70", dec(0), 32'd70);

        // Async reset mid-ramp
        EN = 1'b0;
        TICK_DIV = 24'd0;
        STEP = 16'd450;
        set_ch(2, 28'd1000, 28'd1000);
        cyc(2);
        EN = 1'b1;
        cyc(4);  chk("rst_pre_500", dec(2), 32'd500);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_async_ch2", dec(2), 32'd0);
        chk("rst_async_ch0", dec(0), 32'd0);
        STEP = 16'd100;
        cyc(2);
        RST_N = 1'b1;
        cyc(3);  chk("rst_restart_wait", dec(2), 32'd0);
        cyc(1);  chk("rst_restart_100", dec(2), 32'd100);
        cyc(4);  chk("rst_restart_200", dec(2), 32'd200);

        // Full-range boundary on channel 3
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) set_ch(i, 28'd0, 28'd0);
        set_ch(3, 28'hFFFFFFF, 28'hFFFFFFF);
        STEP = 16'hFFFF;
        TICK_DIV = 24'd0;
        cyc(1);
        RST_N = 1'b1;
        exp_v = 32'd0;
        cyc(1);
        for (int k = 0; k < 4097; k++) begin
            cyc(4);
            exp_v = ((32'h0FFFFFFF - exp_v) <= 32'h0000FFFF) ? 32'h0FFFFFFF : exp_v + 32'h0000FFFF;
            chk("bnd_step", dec(3), exp_v);
        end
        chk("bnd_final", dec(3), 32'h0FFFFFFF);
        chk("bnd_busy", {28'd0, BUSY}, 32'd0);
        cyc(4);  chk("bnd_no_wrap", dec(3), 32'h0FFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
